// File: rtl/maj3_pkg.sv
// Shared constants and types for the maj3 bitwise majority voter.
package maj3_pkg;

    localparam int MAJ3_WIDTH_DEFAULT = 1;
    localparam int MAJ3_WIDTH_MAX     = 64;

    // Bit k inverts operand k (0=A, 1=B, 2=C) ahead of the vote.
    typedef logic [2:0] inv_mask_t;

endpackage

// File: rtl/maj3_bit.sv
// One-bit majority and unanimity cell; maj3 instantiates one per operand bit.
module maj3_bit
    import maj3_pkg::*;
(
    input  logic a,
    input  logic b,
    input  logic c,
    output logic maj,
    output logic unanimous
);

    always_comb begin
        maj       = (a & b) | (a & c) | (b & c);
        unanimous = ~(a ^ b) & ~(b ^ c);
    end

endmodule

// File: rtl/maj3.sv
// WIDTH-bit three-input majority voter with an optional output register.
// Defining MAJ3_INV_EN adds the 3-bit inv port for per-operand inversion.
module maj3
    import maj3_pkg::*;
#(
    parameter int WIDTH   = MAJ3_WIDTH_DEFAULT,
    parameter int REG_OUT = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [WIDTH-1:0] C,
    input  logic             in_valid,
    output logic [WIDTH-1:0] Y,
    output logic [WIDTH-1:0] Y_q,
    output logic             out_valid,
    output logic [WIDTH-1:0] unanimous
`ifdef MAJ3_INV_EN
    ,
    input  inv_mask_t        inv
`endif
);

    logic [WIDTH-1:0] a_eff;
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH-1:0] c_eff;
    logic [WIDTH-1:0] maj_vec;
    logic [WIDTH-1:0] res_d;
    logic [WIDTH-1:0] res_q;
    logic             vld_d;
    logic             vld_q;

    always_comb begin
`ifdef MAJ3_INV_EN
        a_eff = A ^ {WIDTH{inv[0]}};
        b_eff = B ^ {WIDTH{inv[1]}};
        c_eff = C ^ {WIDTH{inv[2]}};
`else
        a_eff = A;
        b_eff = B;
        c_eff = C;
`endif
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        maj3_bit u_bit (
            .a         (a_eff[i]),
            .b         (b_eff[i]),
            .c         (c_eff[i]),
            .maj       (maj_vec[i]),
            .unanimous (unanimous[i])
        );
    end

    // in_valid/out_valid: every edge with in_valid=1 captures a result and
    // raises out_valid for the following cycle only; there is no ready, so
    // the consumer must take Y_q in the cycle out_valid is high.
    always_comb begin
        res_d = res_q;
        vld_d = 1'b0;
        if (in_valid) begin
            res_d = maj_vec;
            vld_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            res_q <= '0;
            vld_q <= 1'b0;
        end else begin
            res_q <= res_d;
            vld_q <= vld_d;
        end
    end

    assign Y_q       = res_q;
    assign out_valid = vld_q;

    if (REG_OUT != 0) begin : g_y_reg
        assign Y = res_q;
    end else begin : g_y_comb
        assign Y = maj_vec;
    end

endmodule

// File: tb/tb_maj3.sv
// Randomized scoreboard bench for maj3 (combinational, registered and 1-bit builds).
module tb_maj3;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic [7:0] a, b, c;
    logic       a1, b1, c1;
    logic [2:0] inv8, inv1;

    logic [7:0] y_comb, yq_comb, un_comb;
    logic [7:0] y_reg, yq_reg, un_reg;
    logic       ov_comb, ov_reg;
    logic       y_w1, yq_w1, ov_w1, un_w1;

    logic [8:0] exp_q[$];
    logic [7:0] mdl_y;
    logic       mdl_v;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    maj3 #(.WIDTH(8), .REG_OUT(0)) u_comb (
        .clk(clk), .rst_n(rst_n), .A(a), .B(b), .C(c), .in_valid(in_valid),
        .Y(y_comb), .Y_q(yq_comb), .out_valid(ov_comb), .unanimous(un_comb)
`ifdef MAJ3_INV_EN
        , .inv(inv8)
`endif
    );

    maj3 #(.WIDTH(8), .REG_OUT(1)) u_reg (
        .clk(clk), .rst_n(rst_n), .A(a), .B(b), .C(c), .in_valid(in_valid),
        .Y(y_reg), .Y_q(yq_reg), .out_valid(ov_reg), .unanimous(un_reg)
`ifdef MAJ3_INV_EN
        , .inv(inv8)
`endif
    );

    maj3 #(.WIDTH(1), .REG_OUT(0)) u_w1 (
        .clk(clk), .rst_n(rst_n), .A(a1), .B(b1), .C(c1), .in_valid(in_valid),
        .Y(y_w1), .Y_q(yq_w1), .out_valid(ov_w1), .unanimous(un_w1)
`ifdef MAJ3_INV_EN
        , .inv(inv1)
`endif
    );

    // Reference model: count the ones in each column of the three operands.
    function automatic logic [7:0] apply_inv(input logic [7:0] v, input logic flip);
`ifdef MAJ3_INV_EN
        return flip ? ~v : v;
`else
        return (flip === 1'bx) ? 8'hxx : v;
`endif
    endfunction

    function automatic int ones(input logic [7:0] x, y, z, input int i);
        return int'(x[i]) + int'(y[i]) + int'(z[i]);
    endfunction

    function automatic logic [7:0] ref_maj(input logic [7:0] x, y, z, input logic [2:0] m);
        logic [7:0] r;
        logic [7:0] xi, yi, zi;
        xi = apply_inv(x, m[0]);
        yi = apply_inv(y, m[1]);
        zi = apply_inv(z, m[2]);
        for (int i = 0; i < 8; i++) r[i] = (ones(xi, yi, zi, i) >= 2);
        return r;
    endfunction

    function automatic logic [7:0] ref_unan(input logic [7:0] x, y, z, input logic [2:0] m);
        logic [7:0] r;
        logic [7:0] xi, yi, zi;
        int n;
        xi = apply_inv(x, m[0]);
        yi = apply_inv(y, m[1]);
        zi = apply_inv(z, m[2]);
        for (int i = 0; i < 8; i++) begin
            n = ones(xi, yi, zi, i);
            r[i] = (n == 0) || (n == 3);
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock cycle of stimulus to the 8-bit voters; pushes the state
    // expected after the capturing edge and checks the combinational outputs.
    task automatic drive(input logic [7:0] da, db, dc, input logic v, input logic r,
                         input logic [2:0] m);
        @(posedge clk);
        #2;
        a = da; b = db; c = dc; in_valid = v; rst_n = r; inv8 = m;
        if (!r) begin
            mdl_y = 8'h00;
            mdl_v = 1'b0;
        end else if (v) begin
            mdl_y = ref_maj(da, db, dc, m);
            mdl_v = 1'b1;
        end else begin
            mdl_v = 1'b0;
        end
        exp_q.push_back({mdl_v, mdl_y});
        #1;
        check("y_comb", y_comb, ref_maj(da, db, dc, m));
        check("unan_comb", un_comb, ref_unan(da, db, dc, m));
        check("unan_reg", un_reg, ref_unan(da, db, dc, m));
    endtask

    // Monitor: entries pushed before an edge describe the state after it.
    initial begin
        logic [8:0] item;
        int n;
        forever begin
            @(posedge clk);
            n = exp_q.size();
            @(negedge clk);
            if (n > 0) begin
                item = exp_q.pop_front();
                check("out_valid_comb", ov_comb, item[8]);
                check("out_valid_reg", ov_reg, item[8]);
                check("y_q_comb", yq_comb, item[7:0]);
                check("y_q_reg", yq_reg, item[7:0]);
                check("y_regout", y_reg, item[7:0]);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] tab_y, tab_u;
        logic [2:0] idx;
        logic m1, m2, m3;
        rst_n = 1'b0; in_valid = 1'b0;
        a = '0; b = '0; c = '0; a1 = 0; b1 = 0; c1 = 0;
        inv8 = 3'b000; inv1 = 3'b000;
        mdl_y = '0; mdl_v = 1'b0;

        // Reset wins over in_valid; combinational outputs keep working meanwhile.
        drive(8'hFF, 8'hFF, 8'hFF, 1'b1, 1'b0, 3'b000);
        drive(8'hFF, 8'hFF, 8'hFF, 1'b1, 1'b0, 3'b000);

        // First edge after release captures; Y is 0xE8 at once.
        drive(8'hF0, 8'hCC, 8'hAA, 1'b1, 1'b1, 3'b000);
        check("y_e8_immediate", y_comb, 8'hE8);
        drive(8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 3'b000);
        check("y_q_e8", yq_reg, 8'hE8);
        check("out_valid_e8", ov_reg, 1'b1);
        for (int k = 0; k < 2; k++) begin
            drive(8'h13, 8'h57, 8'h9B, 1'b0, 1'b1, 3'b000);
            check("pulse_valid_low", ov_reg, 1'b0);
            check("pulse_hold", yq_reg, 8'hE8);
        end

        // Reset with in_valid=1 and all-ones operands.
        drive(8'hFF, 8'hFF, 8'hFF, 1'b1, 1'b0, 3'b000);
        drive(8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 3'b000);
        check("rst_y_q", yq_reg, 8'h00);
        check("rst_out_valid", ov_reg, 1'b0);

        // Exhaustive 1-bit truth table.
        tab_y = 8'hE8;
        tab_u = 8'h81;
        for (int k = 0; k < 8; k++) begin
            idx = k[2:0];
            {a1, b1, c1} = idx;
            #1;
            check("w1_y", y_w1, tab_y[idx]);
            check("w1_unan", un_w1, tab_u[idx]);
        end

        // Borrow/difference chain built from three votes: 1 - 0 - 1.
        a1 = 1'b1; b1 = 1'b0; c1 = 1'b1; #1; m1 = y_w1;
        a1 = 1'b0; b1 = 1'b0; c1 = 1'b1; #1; m2 = y_w1;
        a1 = 1'b1; b1 = m2;   c1 = ~m1;  #1; m3 = y_w1;
        check("sub_bout", m2, 1'b0);
        check("sub_diff", m3, 1'b0);

`ifdef MAJ3_INV_EN
        inv1 = 3'b001; a1 = 1'b1; b1 = 1'b1; c1 = 1'b0;
        #1;
        check("inv_not_a", y_w1, 1'b0);
        check("inv_not_a_ref", y_w1, ref_maj(8'h01, 8'h01, 8'h00, 3'b001) & 8'h01);
        inv1 = 3'b000;
`endif

        for (int k = 0; k < 300; k++) begin
            drive($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255),
                  $urandom_range(0, 9) < 6, $urandom_range(0, 19) != 0,
                  $urandom_range(0, 7));
        end

        drive(8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 3'b000);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
